// File: rtl/sc_pkg.sv
// Shared types and helpers for the stochastic-computing run controller:
// FSM state encoding, result record and stream-length clamping.
package sc_pkg;

    localparam int SC_TW = 8;
    localparam int SC_LW = SC_TW + 1;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        RUN,
        DONE
    } state_t;

    typedef struct packed {
        logic [SC_LW-1:0] ones;
        logic [SC_LW-1:0] len;
        logic             dec;
        logic             early;
        logic             err;
    } result_t;

    // A zero or over-long request means "run the whole SNG period" (2^tw bits).
    function automatic logic [SC_LW-1:0] clamp_len(input logic [SC_LW-1:0] len, input int tw);
        logic [SC_LW-1:0] full_len;
        full_len = SC_LW'(1) << tw;
        if (len == '0 || len > full_len) begin
            return full_len;
        end
        return len;
    endfunction

endpackage

// File: rtl/sc_et_sched_if.sv
// Job request, SNG control and result signals of the run controller.
// The controller takes the slave modport; the job source/sink and SNG model take master.
interface sc_et_sched_if
    import sc_pkg::*;
#(
    parameter int N  = 2,
    parameter int W  = 4,
    parameter int LW = SC_LW
);

    logic          req_valid;
    logic          req_ready;
    logic [N*W-1:0] req_bxs;
    logic [LW-1:0] req_len;
    logic [LW-1:0] req_thr;

    logic          sng_rst_n;
    logic [N*W-1:0] sng_bxs;
    logic          sng_done;
    logic          z_bit;

    logic          res_valid;
    logic          res_ready;
    logic [LW-1:0] res_ones;
    logic [LW-1:0] res_len;
    logic          res_dec;
    logic          res_early;
    logic          res_err;

    modport slave (
        input  req_valid, req_bxs, req_len, req_thr, sng_done, z_bit, res_ready,
        output req_ready, sng_rst_n, sng_bxs,
               res_valid, res_ones, res_len, res_dec, res_early, res_err
    );

    modport master (
        output req_valid, req_bxs, req_len, req_thr, sng_done, z_bit, res_ready,
        input  req_ready, sng_rst_n, sng_bxs,
               res_valid, res_ones, res_len, res_dec, res_early, res_err
    );

endinterface

// File: rtl/sc_et_check.sv
// Combinational termination test on post-update counters: full length reached,
// decision already fixed (threshold met, or unreachable with the bits left), and the decision.
module sc_et_check
    import sc_pkg::*;
#(
    parameter int LW = SC_LW
) (
    input  logic [LW-1:0] ones_i,
    input  logic [LW-1:0] bits_i,
    input  logic [LW-1:0] len_i,
    input  logic [LW-1:0] thr_i,
    output logic          term_full_o,
    output logic          term_early_o,
    output logic          dec_o
);

    // ones <= bits <= len, so the best reachable count never exceeds len and cannot wrap.
    logic [LW-1:0] reach;

    assign reach        = ones_i + (len_i - bits_i);
    assign term_full_o  = (bits_i == len_i);
    assign dec_o        = (ones_i >= thr_i);
    assign term_early_o = dec_o || (reach < thr_i);

endmodule

// File: rtl/sc_et_sched.sv
// Run controller for the bit-pattern-counter SNG: accepts a job, resets and runs the SNG,
// counts ones on z_bit and reports the threshold decision. Define SC_ET_EN for early termination.
module sc_et_sched
    import sc_pkg::*;
#(
    parameter int N  = 2,
    parameter int W  = 4,
    parameter int TW = SC_TW,
    parameter int LW = TW + 1
) (
    input  logic           clk,
    input  logic           rst_n,
    sc_et_sched_if.slave   bus
);

    state_t         state_q;
    logic           req_ready_q;
    logic           sng_rst_n_q;
    logic           res_valid_q;
    logic [N*W-1:0] bxs_q;
    logic [LW-1:0]  len_q;
    logic [LW-1:0]  thr_q;
    logic [LW-1:0]  ones_q;
    logic [LW-1:0]  bits_q;
    result_t        res_q;

    logic [LW-1:0]  ones_d;
    logic [LW-1:0]  bits_d;
    result_t        res_d;
    logic           term_full;
    logic           term_early;
    logic           dec;
    logic           early_hit;
    logic           err_hit;
    logic           term;

    assign ones_d = ones_q + LW'(bus.z_bit);
    assign bits_d = bits_q + LW'(1);

    sc_et_check #(
        .LW (LW)
    ) u_check (
        .ones_i       (ones_d),
        .bits_i       (bits_d),
        .len_i        (len_q),
        .thr_i        (thr_q),
        .term_full_o  (term_full),
        .term_early_o (term_early),
        .dec_o        (dec)
    );

`ifdef SC_ET_EN
    assign early_hit = term_early && !term_full;
`else
    logic unused_term_early;
    assign unused_term_early = term_early;
    assign early_hit         = 1'b0;
`endif

    // Priority full > early > err; sng_done only matters while bits are still owed.
    assign err_hit = bus.sng_done && !term_full && !early_hit;
    assign term    = term_full || early_hit || err_hit;

    always_comb begin
        res_d       = '0;
        res_d.ones  = ones_d;
        res_d.len   = bits_d;
        res_d.dec   = dec;
        res_d.early = early_hit;
        res_d.err   = err_hit;
    end

    // NOTE: every register updates with <= so all branches see the pre-edge values of each other.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            req_ready_q <= 1'b1;
            sng_rst_n_q <= 1'b0;
            res_valid_q <= 1'b0;
            bxs_q       <= '0;
            len_q       <= '0;
            thr_q       <= '0;
            ones_q      <= '0;
            bits_q      <= '0;
            res_q       <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.req_valid) begin
                        bxs_q       <= bus.req_bxs;
                        len_q       <= clamp_len(bus.req_len, TW);
                        thr_q       <= bus.req_thr;
                        ones_q      <= '0;
                        bits_q      <= '0;
                        req_ready_q <= 1'b0;
                        state_q     <= LOAD;
                    end
                end
                LOAD: begin
                    sng_rst_n_q <= 1'b1;
                    state_q     <= RUN;
                end
                RUN: begin
                    ones_q <= ones_d;
                    bits_q <= bits_d;
                    if (term) begin
                        res_q       <= res_d;
                        res_valid_q <= 1'b1;
                        sng_rst_n_q <= 1'b0;
                        state_q     <= DONE;
                    end
                end
                DONE: begin
                    if (bus.res_ready) begin
                        res_valid_q <= 1'b0;
                        req_ready_q <= 1'b1;
                        state_q     <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.req_ready = req_ready_q;
    assign bus.sng_rst_n = sng_rst_n_q;
    assign bus.sng_bxs   = bxs_q;
    assign bus.res_valid = res_valid_q;
    assign bus.res_ones  = res_q.ones;
    assign bus.res_len   = res_q.len;
    assign bus.res_dec   = res_q.dec;
    assign bus.res_early = res_q.early;
    assign bus.res_err   = res_q.err;

endmodule

// File: tb/tb_sc_et_sched.sv
// Scoreboard bench for sc_et_sched: directed jobs push hand-computed results,
// a monitor pops and compares when res_valid rises. Expectations follow SC_ET_EN.
module tb_sc_et_sched;

`ifdef SC_ET_EN
    localparam bit ET = 1'b1;
`else
    localparam bit ET = 1'b0;
`endif

    typedef struct {
        int         id;
        logic [8:0] ones;
        logic [8:0] len;
        logic       dec;
        logic       early;
        logic       err;
        int         cyc;
    } exp_t;

    logic clk;
    logic rst_n;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;
    exp_t exp_q[$];

    int job_t0   = -1000;
    int z_mode   = 0;
    int done_bit = -1;

    sc_et_sched_if #(.N(2), .W(4), .LW(9)) bus ();

    sc_et_sched #(.N(2), .W(4), .TW(8), .LW(9)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, req);
        end
    endtask

    // SNG / SC-circuit model: z pattern per job, sng_done during LOAD (must be ignored)
    // and optionally on a chosen bit index.
    initial begin
        bus.z_bit    = 1'b0;
        bus.sng_done = 1'b0;
        forever begin
            int i;
            @(negedge clk);
            i = cyc - job_t0 - 2;
            case (z_mode)
                1:       bus.z_bit = (i >= 0);
                2:       bus.z_bit = (i >= 0) && (i % 2 == 0);
                default: bus.z_bit = 1'b0;
            endcase
            bus.sng_done = (i == -1) || (done_bit >= 0 && i == done_bit - 1);
        end
    end

    // Monitor: one pop per result presentation.
    initial begin
        logic prev_valid;
        prev_valid = 1'b0;
        forever begin
            @(negedge clk);
            if (bus.res_valid && !prev_valid) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_result", 32'(bus.res_valid), 32'd0);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    check($sformatf("job%0d_ones", e.id),  32'(bus.res_ones),  32'(e.ones));
                    check($sformatf("job%0d_len", e.id),   32'(bus.res_len),   32'(e.len));
                    check($sformatf("job%0d_dec", e.id),   32'(bus.res_dec),   32'(e.dec));
                    check($sformatf("job%0d_early", e.id), 32'(bus.res_early), 32'(e.early));
                    check($sformatf("job%0d_err", e.id),   32'(bus.res_err),   32'(e.err));
                    check($sformatf("job%0d_cycle", e.id), 32'(cyc),           32'(e.cyc));
                end
            end
            prev_valid = bus.res_valid;
        end
    end

    task automatic send_job(input int id, input logic [7:0] bxs, input logic [8:0] len,
                            input logic [8:0] thr, input int mode, input int dbit,
                            input bit expect_res, input logic [8:0] e_ones,
                            input logic [8:0] e_len, input bit e_dec, input bit e_early,
                            input bit e_err, input int lat);
        int   n;
        exp_t e;
        @(negedge clk);
        bus.req_valid = 1'b1;
        bus.req_bxs   = bxs;
        bus.req_len   = len;
        bus.req_thr   = thr;
        n = 0;
        while (!bus.req_ready && n < 1000) begin
            @(negedge clk);
            n++;
        end
        if (n >= 1000) begin
            check($sformatf("job%0d_accept_timeout", id), 32'd0, 32'd1);
            bus.req_valid = 1'b0;
            return;
        end
        job_t0   = cyc;
        z_mode   = mode;
        done_bit = dbit;
        if (expect_res) begin
            e = '{id: id, ones: e_ones, len: e_len, dec: e_dec, early: e_early,
                  err: e_err, cyc: cyc + lat};
            exp_q.push_back(e);
        end
        @(posedge clk);
        #1;
        bus.req_valid = 1'b0;
        @(negedge clk);
        check($sformatf("job%0d_load_sng_rst_n", id), 32'(bus.sng_rst_n), 32'd0);
        check($sformatf("job%0d_sng_bxs", id),        32'(bus.sng_bxs),   32'(bxs));
        check($sformatf("job%0d_load_req_ready", id), 32'(bus.req_ready), 32'd0);
        @(negedge clk);
        check($sformatf("job%0d_run_sng_rst_n", id),  32'(bus.sng_rst_n), 32'd1);
    endtask

    task automatic wait_drain(input int id);
        int n;
        n = 0;
        while ((exp_q.size() != 0 || bus.res_valid) && n < 1000) begin
            @(negedge clk);
            n++;
        end
        if (n >= 1000) check($sformatf("job%0d_result_timeout", id), 32'd0, 32'd1);
    endtask

    initial begin
        #500000;
        $display("FAIL global_timeout: got cycle %0d expected finish", cyc);
        $fatal(1, "bench timeout");
    end

    initial begin
        rst_n         = 1'b0;
        bus.req_valid = 1'b0;
        bus.req_bxs   = '0;
        bus.req_len   = '0;
        bus.req_thr   = '0;
        bus.res_ready = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_req_ready", 32'(bus.req_ready), 32'd1);
        check("rst_res_valid", 32'(bus.res_valid), 32'd0);
        check("rst_sng_rst_n", 32'(bus.sng_rst_n), 32'd0);
        check("rst_sng_bxs",   32'(bus.sng_bxs),   32'd0);
        check("rst_res_ones",  32'(bus.res_ones),  32'd0);
        check("rst_res_len",   32'(bus.res_len),   32'd0);
        rst_n = 1'b1;

        // 1: all ones, len 16, thr 8
        send_job(1, 8'hA5, 9'd16, 9'd8, 1, -1, 1'b1,
                 ET ? 9'd8 : 9'd16, ET ? 9'd8 : 9'd16, 1'b1, ET, 1'b0, ET ? 10 : 18);
        wait_drain(1);
        // 2: all zeros; the decision is lost at bit 9 (0 + 7 < 8)
        send_job(2, 8'h3C, 9'd16, 9'd8, 0, -1, 1'b1,
                 9'd0, ET ? 9'd9 : 9'd16, 1'b0, ET, 1'b0, ET ? 11 : 18);
        wait_drain(2);
        // 3: alternating 1,0; the 8th one arrives on bit 15
        send_job(3, 8'h5A, 9'd16, 9'd8, 2, -1, 1'b1,
                 9'd8, ET ? 9'd15 : 9'd16, 1'b1, ET, 1'b0, ET ? 17 : 18);
        wait_drain(3);
        // 4: len 0 clamps to 256, SNG overflow reported on bit 100
        send_job(4, 8'hF0, 9'd0, 9'd200, 1, 100, 1'b1,
                 9'd100, 9'd100, 1'b0, 1'b0, 1'b1, 102);
        wait_drain(4);
        // 5: thr 0 is decided by the first bit
        send_job(5, 8'h0F, 9'd4, 9'd0, 0, -1, 1'b1,
                 9'd0, ET ? 9'd1 : 9'd4, 1'b1, ET, 1'b0, ET ? 3 : 6);
        wait_drain(5);

        // 6: thr above len, result held under back-pressure while job 7 is offered
        bus.res_ready = 1'b0;
        send_job(6, 8'h81, 9'd4, 9'd20, 1, -1, 1'b1,
                 ET ? 9'd1 : 9'd4, ET ? 9'd1 : 9'd4, 1'b0, ET, 1'b0, ET ? 3 : 6);
        fork
            begin
                int n;
                n = 0;
                while (!bus.res_valid && n < 100) begin
                    @(negedge clk);
                    n++;
                end
                if (n >= 100) check("job6_valid_timeout", 32'd0, 32'd1);
                for (int k = 0; k < 5; k++) begin
                    if (k != 0) @(negedge clk);
                    check($sformatf("stall%0d_res_valid", k), 32'(bus.res_valid), 32'd1);
                    check($sformatf("stall%0d_req_ready", k), 32'(bus.req_ready), 32'd0);
                    check($sformatf("stall%0d_ones", k), 32'(bus.res_ones), ET ? 32'd1 : 32'd4);
                    check($sformatf("stall%0d_len", k),  32'(bus.res_len),  ET ? 32'd1 : 32'd4);
                end
                bus.res_ready = 1'b1;
            end
            // 7: len 300 clamps to 256; full and early coincide, full wins
            send_job(7, 8'h42, 9'd300, 9'd256, 1, -1, 1'b1,
                     9'd256, 9'd256, 1'b1, 1'b0, 1'b0, 258);
        join
        wait_drain(7);

        // 8: reset mid-run abandons the job without a result
        send_job(8, 8'h99, 9'd16, 9'd8, 1, -1, 1'b0,
                 9'd0, 9'd0, 1'b0, 1'b0, 1'b0, 0);
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        check("midrst_res_valid", 32'(bus.res_valid), 32'd0);
        check("midrst_sng_rst_n", 32'(bus.sng_rst_n), 32'd0);
        check("midrst_req_ready", 32'(bus.req_ready), 32'd1);
        repeat (30) @(negedge clk);
        check("midrst_pending", 32'(exp_q.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
